avg_sample_sequencer: RTL and testbench
=======================================

Name: avg_sample_sequencer

Overview:
Controller that schedules periodic accelerometer sampling and feeds the averaging datapath. On each sample tick it requests the four channels (X, Y, Z, T) one at a time from the SPI read engine, with a per-read timeout, and assembles them into one coherent sample. It then presents the sample with a one-cycle dataReady pulse to the averaging stage. It also tracks averaging-window boundaries and reports missed ticks.

Parameters:
SAMPLE_PERIOD, 100000, clk cycles between sample ticks (>=8).
TIMEOUT, 4096, max clk cycles to wait for i_SPI_Done per channel read (>=2).
WINDOW, 16, samples per averaging window; matches the averager depth (>=1).

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
i_SEQ_Enable  in  1  level; 1 = sampling active.
o_SPI_Start  out  1  one-cycle read request to the SPI engine.
o_SPI_Axis  out  2  channel select for the request: 0=X, 1=Y, 2=Z, 3=T; stable from Start until Done or timeout.
i_SPI_Done  in  1  one-cycle pulse; i_SPI_Data valid in the same cycle.
i_SPI_Data  in  19  read result; X/Y/Z use bits [11:0], T uses [18:0].
o_ACCEL_X / o_ACCEL_Y / o_ACCEL_Z  out  12 each  signed sample, held between publishes.
o_ACCEL_T  out  19  signed temperature sample, held between publishes.
o_AVG_dataReady  out  1  one-cycle pulse; o_ACCEL_* hold the new sample in that same cycle.
o_SEQ_WindowDone  out  1  one-cycle pulse, coincident with the dataReady that completes a window.
o_SEQ_Error  out  1  one-cycle pulse on read timeout.
o_SEQ_Overrun  out  1  one-cycle pulse when a tick is dropped.
o_SEQ_Busy  out  1  high in every state except IDLE and WAIT_TICK.

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Period, timeout, axis and sample counters and the capture registers clear to 0.
- FSM states and transitions:
  - IDLE: period counter held at 0. Goes to WAIT_TICK the cycle after i_SEQ_Enable=1.
  - WAIT_TICK: waits for a tick. On a tick, sets axis=0 and goes to REQ. If i_SEQ_Enable=0 (and no tick this cycle), goes to IDLE.
  - REQ: o_SPI_Start=1 for exactly one cycle with o_SPI_Axis=axis; clears the timeout counter; goes to WAIT_DONE.
  - WAIT_DONE: timeout counter increments each cycle.
    - On i_SPI_Done, i_SPI_Data is captured into the shadow register for that axis. If axis=3, go to PUBLISH; otherwise axis+1 and go to REQ.
    - If the counter reaches TIMEOUT-1 with no Done: pulse o_SEQ_Error, discard the partial sample (shadows are not published), go to WAIT_TICK.
    - Done and timeout in the same cycle: Done wins, no error.
  - PUBLISH: all four o_ACCEL_* load from the shadows on the same edge that raises o_AVG_dataReady for one cycle.
    - Sample counter increments. If it was WINDOW-1, it wraps to 0 and o_SEQ_WindowDone pulses together with dataReady.
    - Then go to WAIT_TICK.
- Tick generation:
  - Period counter free-runs 0..SAMPLE_PERIOD-1 in every state except IDLE; the tick is the cycle where it equals SAMPLE_PERIOD-1.
  - First tick comes SAMPLE_PERIOD cycles after leaving IDLE.
  - A tick that occurs outside WAIT_TICK is dropped and o_SEQ_Overrun pulses; the schedule stays periodic, with no catch-up.
- Latency:
  - Tick to o_SPI_Start: 1 cycle.
  - Final Done to o_AVG_dataReady: 1 cycle.
- Enable:
  - Deassertion takes effect only in WAIT_TICK; an in-flight sample completes and publishes.
  - Re-enable restarts the period phase from 0. The sample/window counter is not cleared by enable, only by reset.
- Spurious input: i_SPI_Done outside WAIT_DONE is ignored.
- Reset mid-sample: aborts immediately with no publish and no error pulse. The averager sees no dataReady until a full new sample completes.
- Data mapping: X/Y/Z take i_SPI_Data[11:0] verbatim, no sign extension or rescaling; T takes [18:0].

Optional Feature:
SEQ_OVERRUN_CNT_EN.
- Defined: adds output port o_SEQ_OverrunCount [7:0].
  - Saturating count of dropped ticks, held at 255.
  - Cleared by reset, and cleared when i_SEQ_Enable rises.
  - Increments in the same cycle as o_SEQ_Overrun.
- Undefined: port and counter are absent; only the o_SEQ_Overrun pulse exists.

Test Plan (SAMPLE_PERIOD=20, TIMEOUT=8, WINDOW=4):
1. Enable, SPI model answers each Start after 2 cycles with X=0x7FF, Y=0x800, Z=0x001, T=0x3FFFF.
   - First o_SPI_Start occurs 21 cycles after enable.
   - Axis sequence 0,1,2,3.
   - dataReady 1 cycle after the 4th Done, with exactly those values; repeats every 20 cycles.
2. Run 4 samples -> o_SEQ_WindowDone pulses with the 4th dataReady only; 8 samples -> pulses on the 4th and 8th.
3. SPI model never answers axis 1 -> o_SEQ_Error 8 cycles after that Start; no dataReady; o_ACCEL_* keep their previous values; next tick restarts at axis 0.
4. Done and timeout in the same cycle -> no Error; sample completes normally.
5. SPI delay of 6 cycles per read (sample longer than 20 cycles) -> o_SEQ_Overrun pulses once per dropped tick; with SEQ_OVERRUN_CNT_EN, the count matches and saturates at 255.
6. Reset asserted while waiting for the axis-2 Done -> next cycle all outputs are 0 and the FSM is IDLE; a late Done is ignored.
   - Enable deasserted mid-sample -> sample still publishes, then the FSM goes to IDLE.

Source files
------------

// File: rtl/avg_sample_sequencer.sv
// Periodic four-channel (X,Y,Z,T) sample sequencer feeding the averaging stage.
// Optional dropped-tick counter port o_SEQ_OverrunCount enabled by `define SEQ_OVERRUN_CNT_EN.
module avg_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int TIMEOUT       = 4096,
  parameter int WINDOW        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_SEQ_Enable,
  output logic        o_SPI_Start,
  output logic [1:0]  o_SPI_Axis,
  input  logic        i_SPI_Done,
  input  logic [18:0] i_SPI_Data,
  output logic [11:0] o_ACCEL_X,
  output logic [11:0] o_ACCEL_Y,
  output logic [11:0] o_ACCEL_Z,
  output logic [18:0] o_ACCEL_T,
  output logic        o_AVG_dataReady,
  output logic        o_SEQ_WindowDone,
  output logic        o_SEQ_Error,
  output logic        o_SEQ_Overrun,
  output logic        o_SEQ_Busy
`ifdef SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]  o_SEQ_OverrunCount
`endif
);

  // state      | meaning
  // IDLE       | sampling disabled, period counter held at 0
  // WAIT_TICK  | waiting for the next sample tick
  // REQ        | one-cycle read request for the current axis
  // WAIT_DONE  | waiting for the SPI read result, timeout running
  // PUBLISH    | new sample on o_ACCEL_*, dataReady high

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WINDOW_LAST  = WW'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_REQ,
    S_WAIT_DONE,
    S_PUBLISH
  } state_t;

  state_t state, state_next;

  logic [PW-1:0] period_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [WW-1:0] sample_cnt;
  logic [1:0]    axis;
  logic [11:0]   shadow_x, shadow_y, shadow_z;
  logic          tick, timeout_hit, window_last, read_done;

  assign tick        = (state != S_IDLE) && (period_cnt == PERIOD_LAST);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
  assign window_last = (sample_cnt == WINDOW_LAST);
  assign read_done   = (state == S_WAIT_DONE) && i_SPI_Done;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (i_SEQ_Enable) state_next = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (tick)               state_next = S_REQ;
        else if (!i_SEQ_Enable) state_next = S_IDLE;
      end
      S_REQ:       state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // a Done landing on the last timeout cycle still counts
        if (i_SPI_Done)       state_next = (axis == 2'd3) ? S_PUBLISH : S_REQ;
        else if (timeout_hit) state_next = S_WAIT_TICK;
      end
      S_PUBLISH:   state_next = S_WAIT_TICK;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_SPI_Start      = 1'b0;
    o_AVG_dataReady  = 1'b0;
    o_SEQ_WindowDone = 1'b0;
    o_SEQ_Error      = 1'b0;
    o_SEQ_Busy       = 1'b0;
    case (state)
      S_REQ: begin
        o_SPI_Start = 1'b1;
        o_SEQ_Busy  = 1'b1;
      end
      S_WAIT_DONE: begin
        o_SEQ_Busy  = 1'b1;
        o_SEQ_Error = !i_SPI_Done && timeout_hit;
      end
      S_PUBLISH: begin
        o_SEQ_Busy       = 1'b1;
        o_AVG_dataReady  = 1'b1;
        o_SEQ_WindowDone = window_last;
      end
      default: ;
    endcase
  end

  assign o_SEQ_Overrun = tick && (state != S_WAIT_TICK);
  assign o_SPI_Axis    = axis;

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt  <= '0;
      timeout_cnt <= '0;
      sample_cnt  <= '0;
      axis        <= 2'd0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      shadow_z    <= '0;
      o_ACCEL_X   <= '0;
      o_ACCEL_Y   <= '0;
      o_ACCEL_Z   <= '0;
      o_ACCEL_T   <= '0;
    end else begin
      // phase restarts from 0 on every exit from IDLE
      if (state == S_IDLE || state_next == S_IDLE) period_cnt <= '0;
      else if (period_cnt == PERIOD_LAST)          period_cnt <= '0;
      else                                         period_cnt <= period_cnt + PW'(1);

      if (state == S_REQ)            timeout_cnt <= '0;
      else if (state == S_WAIT_DONE) timeout_cnt <= timeout_cnt + TW'(1);

      if (state == S_WAIT_TICK && tick)   axis <= 2'd0;
      else if (read_done && axis != 2'd3) axis <= axis + 2'd1;

      if (read_done) begin
        case (axis)
          2'd0:    shadow_x <= i_SPI_Data[11:0];
          2'd1:    shadow_y <= i_SPI_Data[11:0];
          2'd2:    shadow_z <= i_SPI_Data[11:0];
          default: ;
        endcase
      end

      // T is published straight from the bus so the outputs change with dataReady
      if (read_done && axis == 2'd3) begin
        o_ACCEL_X <= shadow_x;
        o_ACCEL_Y <= shadow_y;
        o_ACCEL_Z <= shadow_z;
        o_ACCEL_T <= i_SPI_Data;
      end

      if (state == S_PUBLISH) sample_cnt <= window_last ? '0 : sample_cnt + WW'(1);
    end
  end

`ifdef SEQ_OVERRUN_CNT_EN
  logic       enable_q;
  logic [7:0] overrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      enable_q <= i_SEQ_Enable;
      if (i_SEQ_Enable && !enable_q)                overrun_cnt <= 8'd0;
      else if (o_SEQ_Overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign o_SEQ_OverrunCount = overrun_cnt;
`endif

endmodule

// File: tb/tb_avg_sample_sequencer.sv
// Self-checking bench for avg_sample_sequencer: timestamp-based sample model plus literal pins.
module tb_avg_sample_sequencer;
  localparam int P   = 20;
  localparam int TO  = 8;
  localparam int WIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_SEQ_Enable;
  logic        i_SPI_Done = 1'b0;
  logic [18:0] i_SPI_Data = 19'h0;
  logic        o_SPI_Start;
  logic [1:0]  o_SPI_Axis;
  logic [11:0] o_ACCEL_X, o_ACCEL_Y, o_ACCEL_Z;
  logic [18:0] o_ACCEL_T;
  logic        o_AVG_dataReady, o_SEQ_WindowDone, o_SEQ_Error, o_SEQ_Overrun, o_SEQ_Busy;
`ifdef SEQ_OVERRUN_CNT_EN
  logic [7:0]  o_SEQ_OverrunCount;
`endif

  avg_sample_sequencer #(.SAMPLE_PERIOD(P), .TIMEOUT(TO), .WINDOW(WIN)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_SEQ_Enable     (i_SEQ_Enable),
    .o_SPI_Start      (o_SPI_Start),
    .o_SPI_Axis       (o_SPI_Axis),
    .i_SPI_Done       (i_SPI_Done),
    .i_SPI_Data       (i_SPI_Data),
    .o_ACCEL_X        (o_ACCEL_X),
    .o_ACCEL_Y        (o_ACCEL_Y),
    .o_ACCEL_Z        (o_ACCEL_Z),
    .o_ACCEL_T        (o_ACCEL_T),
    .o_AVG_dataReady  (o_AVG_dataReady),
    .o_SEQ_WindowDone (o_SEQ_WindowDone),
    .o_SEQ_Error      (o_SEQ_Error),
    .o_SEQ_Overrun    (o_SEQ_Overrun),
    .o_SEQ_Busy       (o_SEQ_Busy)
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    .o_SEQ_OverrunCount (o_SEQ_OverrunCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // stimulus controls (written by the main sequence)
  int          phase = 0;
  int          resp_delay = 2;
  int          drop_axis = -1;
  logic [18:0] r_val [4];
  bit          check_en = 0;
  bit          wait_expired = 0;

  // SPI responder schedule (written by the compare process)
  int       resp_at = -1;
  logic [1:0] resp_axis = 2'd0;

  always @(posedge clk) begin
    #1;
    if (resp_at == cyc) begin
      i_SPI_Done = 1'b1;
      i_SPI_Data = r_val[resp_axis];
    end else begin
      i_SPI_Done = 1'b0;
      i_SPI_Data = 19'h2A5A5;
    end
  end

  // model: tick phase by origin timestamp, in-flight sample by request/publish timestamps
  bit          m_active = 0, m_busy = 0, m_prev_en = 0;
  int          m_origin = 0, m_start_at = -1, m_req_at = -1, m_pub_at = -1;
  int          m_axis = 0, m_samples = 0, m_ovr_cnt = 0;
  logic [18:0] m_sh [4];
  logic [11:0] m_x = 12'h0, m_y = 12'h0, m_z = 12'h0;
  logic [18:0] m_t = 19'h0;
  bit          m_tick, m_wait, e_start, e_err, e_rdy, e_wd, e_ovr;

  // literal-pin bookkeeping
  bit lit_prev_en = 0, lit_start_pending = 0, prev_reset = 0;
  int lit_en_cyc = -1, last_start = -1, last_done = -1, last_ready = -1, ready_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    m_tick  = m_active && ((cyc - m_origin) % P == P - 1);
    m_wait  = m_busy && (m_pub_at < 0) && (cyc > m_req_at);
    e_start = m_busy && (cyc == m_start_at);
    e_err   = m_wait && !i_SPI_Done && (cyc == m_req_at + TO);
    e_rdy   = m_busy && (cyc == m_pub_at);
    e_wd    = e_rdy && (m_samples % WIN == WIN - 1);
    e_ovr   = m_tick && m_busy;

    if (check_en) begin
      chk("spi_start",   int'(o_SPI_Start),      int'(e_start));
      chk("spi_axis",    int'(o_SPI_Axis),       m_axis);
      chk("data_ready",  int'(o_AVG_dataReady),  int'(e_rdy));
      chk("window_done", int'(o_SEQ_WindowDone), int'(e_wd));
      chk("seq_error",   int'(o_SEQ_Error),      int'(e_err));
      chk("seq_overrun", int'(o_SEQ_Overrun),    int'(e_ovr));
      chk("seq_busy",    int'(o_SEQ_Busy),       int'(m_busy));
      chk("accel_x",     int'(o_ACCEL_X),        int'(m_x));
      chk("accel_y",     int'(o_ACCEL_Y),        int'(m_y));
      chk("accel_z",     int'(o_ACCEL_Z),        int'(m_z));
      chk("accel_t",     int'(o_ACCEL_T),        int'(m_t));
`ifdef SEQ_OVERRUN_CNT_EN
      chk("overrun_count", int'(o_SEQ_OverrunCount), m_ovr_cnt);
`endif
      chk("wait_bound", int'(wait_expired), 0);

      if (lit_start_pending && o_SPI_Start) begin
        chk("first_start_latency", cyc - lit_en_cyc, 21);
        lit_start_pending = 0;
      end
      if (phase == 1 && o_AVG_dataReady) begin
        chk("lit_x", int'(o_ACCEL_X), 'h7FF);
        chk("lit_y", int'(o_ACCEL_Y), 'h800);
        chk("lit_z", int'(o_ACCEL_Z), 'h001);
        chk("lit_t", int'(o_ACCEL_T), 'h3FFFF);
        chk("ready_after_done", cyc - last_done, 1);
        chk("window_literal", int'(o_SEQ_WindowDone), int'((ready_n % 4) == 3));
        if (last_ready >= 0) chk("ready_period", cyc - last_ready, 20);
        last_ready = cyc;
        ready_n++;
      end
      if (phase == 3 && o_SEQ_Error) begin
        chk("timeout_latency", cyc - last_start, 8);
        chk("timeout_axis", int'(o_SPI_Axis), 1);
      end
      if (phase == 4) chk("no_error_on_tie", int'(o_SEQ_Error), 0);
      if (phase == 6 && prev_reset) begin
        chk("rst_ctrl", int'({o_SPI_Start, o_SPI_Axis, o_AVG_dataReady, o_SEQ_WindowDone,
                              o_SEQ_Error, o_SEQ_Overrun, o_SEQ_Busy}), 0);
        chk("rst_xyz", int'({o_ACCEL_X, o_ACCEL_Y}) | int'(o_ACCEL_Z), 0);
        chk("rst_t", int'(o_ACCEL_T), 0);
      end
    end

    if (reset) begin
      m_active = 0; m_busy = 0; m_prev_en = 0;
      m_axis = 0; m_samples = 0; m_ovr_cnt = 0;
      m_start_at = -1; m_req_at = -1; m_pub_at = -1;
      m_x = 12'h0; m_y = 12'h0; m_z = 12'h0; m_t = 19'h0;
    end else begin
      if (i_SEQ_Enable && !m_prev_en) m_ovr_cnt = 0;
      else if (e_ovr && m_ovr_cnt < 255) m_ovr_cnt++;
      m_prev_en = i_SEQ_Enable;

      if (!m_active) begin
        if (i_SEQ_Enable) begin
          m_active = 1;
          m_origin = cyc + 1;
        end
      end else if (!m_busy) begin
        if (m_tick) begin
          m_busy = 1; m_axis = 0; m_pub_at = -1;
          m_req_at = cyc + 1; m_start_at = cyc + 1;
        end else if (!i_SEQ_Enable) begin
          m_active = 0;
        end
      end else if (cyc == m_pub_at) begin
        m_busy = 0;
        m_samples++;
      end else if (m_wait) begin
        if (i_SPI_Done) begin
          m_sh[m_axis] = i_SPI_Data;
          if (m_axis == 3) begin
            m_pub_at = cyc + 1;
            m_x = m_sh[0][11:0];
            m_y = m_sh[1][11:0];
            m_z = m_sh[2][11:0];
            m_t = m_sh[3];
          end else begin
            m_axis++;
            m_req_at = cyc + 1;
            m_start_at = cyc + 1;
          end
        end else if (cyc == m_req_at + TO) begin
          m_busy = 0;
        end
      end
    end

    if (o_SPI_Start && int'(o_SPI_Axis) != drop_axis) begin
      resp_at = cyc + resp_delay;
      resp_axis = o_SPI_Axis;
    end
    if (o_SPI_Start) last_start = cyc;
    if (i_SPI_Done) last_done = cyc;
    if (i_SEQ_Enable && !lit_prev_en) begin
      lit_en_cyc = cyc;
      lit_start_pending = 1;
    end
    lit_prev_en = i_SEQ_Enable;
    prev_reset = reset;
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start_axis(input int ax);
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_SPI_Start && int'(o_SPI_Axis) == ax) found = 1;
    end
    if (!found) wait_expired = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_SEQ_Enable = 1'b0;
    r_val[0] = 19'h007FF;
    r_val[1] = 19'h00800;
    r_val[2] = 19'h00001;
    r_val[3] = 19'h3FFFF;
    run(3);
    check_en = 1;
    reset = 1'b0;

    // nominal sampling, two full windows
    phase = 1;
    i_SEQ_Enable = 1'b1;
    run(21 + 8 * 20 + 5);

    // axis 1 never answered, upper junk bits on X/Y/Z
    phase = 3;
    r_val[0] = 19'h55123;
    r_val[1] = 19'h2AABC;
    r_val[2] = 19'h7FFFF;
    r_val[3] = 19'h40001;
    drop_axis = 1;
    run(40);
    drop_axis = -1;
    run(45);

    // Done on the last timeout cycle
    phase = 4;
    resp_delay = 8;
    run(120);

    // long reads drop ticks
    phase = 5;
    resp_delay = 6;
    run(200);
`ifdef SEQ_OVERRUN_CNT_EN
    run(10600);
`endif

    // reset while waiting for the axis-2 result
    phase = 6;
    resp_delay = 2;
    r_val[0] = 19'h00ABC;
    wait_start_axis(2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(30);

    // disable mid-sample, then re-enable
    phase = 7;
    wait_start_axis(1);
    i_SEQ_Enable = 1'b0;
    run(60);
    i_SEQ_Enable = 1'b1;
    run(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
